g1_update_ctrl: RTL and testbench

//  Sequencer that owns the write side of one G1 rule table (171-bit entries, 11-bit address, 1-cycle registered read).

---
 rtl/g1_update_ctrl.sv | 145 ++++++++++++++
 tb/tb_g1_update_ctrl.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/g1_update_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// g1_update_ctrl : insert/delete sequencer for one G1 rule table.
// It scans the table for a free slot or a matching ruleID, writes the slot
// back and returns a status response.
// Revision: 1.0
// ---------------------------------------------------------------------------
module g1_update_ctrl #(
    parameter int TABLE_ENTRY_SIZE = 154,
    parameter int ENTRY_W          = 171,
    parameter int ADDR_W           = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_op,
    input  logic [ENTRY_W-1:0] req_entry,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp_ok,
    output logic [ADDR_W-1:0]  resp_addr,
    output logic [ADDR_W-1:0]  tbl_addr,
    output logic               tbl_we,
    output logic [ENTRY_W-1:0] tbl_din,
    input  logic [ENTRY_W-1:0] tbl_dout
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TABLE_ENTRY_SIZE);
    localparam logic [10:0]       EMPTY_ID  = 11'h7FF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                    state_q;
    logic                      op_q;
    logic [ENTRY_W-1:ADDR_W]   entry_q;
    logic [ADDR_W-1:0]         tbl_addr_q;
    logic [ADDR_W-1:0]         cmp_q;
    logic                      cmp_vld_q;
    logic                      tbl_we_q;
    logic [ENTRY_W-1:0]        tbl_din_q;
    logic                      resp_valid_q;
    logic                      resp_ok_q;
    logic [ADDR_W-1:0]         resp_addr_q;

    logic [10:0] w_rule_id;
    logic [10:0] w_dout_id;
    logic        w_hit;
    logic        w_unused;

    assign w_rule_id = entry_q[21:11];
    assign w_dout_id = tbl_dout[21:11];
    // tbl_dout lags tbl_addr by one cycle, so cmp_q trails the issue pointer.
    assign w_hit     = cmp_vld_q && (op_q ? (w_dout_id == w_rule_id) : (w_dout_id == EMPTY_ID));
    assign w_unused  = ^{tbl_dout[ENTRY_W-1:22], tbl_dout[10:0], req_entry[ADDR_W-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= 1'b0;
            entry_q      <= '0;
            tbl_addr_q   <= '0;
            cmp_q        <= '0;
            cmp_vld_q    <= 1'b0;
            tbl_we_q     <= 1'b0;
            tbl_din_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_ok_q    <= 1'b0;
            resp_addr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        entry_q <= req_entry[ENTRY_W-1:ADDR_W];
                        if (req_entry[21:11] == EMPTY_ID) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_ok_q    <= 1'b0;
                            resp_addr_q  <= '0;
                        end else begin
                            state_q    <= SCAN;
                            tbl_addr_q <= '0;
                            cmp_q      <= '0;
                            cmp_vld_q  <= 1'b0;
                        end
                    end
                end
                SCAN: begin
                    if (tbl_addr_q != LAST_ADDR) begin
                        tbl_addr_q <= tbl_addr_q + 1'b1;
                    end
                    cmp_vld_q <= 1'b1;
                    if (cmp_vld_q) begin
                        cmp_q <= cmp_q + 1'b1;
                    end
                    if (w_hit) begin
                        state_q    <= WRITE;
                        tbl_we_q   <= 1'b1;
                        tbl_addr_q <= cmp_q;
                        tbl_din_q  <= op_q ? '1 : {entry_q, cmp_q};
                    end else if (cmp_vld_q && (cmp_q == LAST_ADDR)) begin
                        // A miss still spends one idle WRITE cycle so hit and
                        // miss responses share the same pipeline depth.
                        state_q    <= WRITE;
                        tbl_addr_q <= '0;
                    end
                end
                WRITE: begin
                    state_q      <= RESP;
                    tbl_we_q     <= 1'b0;
                    tbl_addr_q   <= '0;
                    tbl_din_q    <= '0;
                    resp_valid_q <= 1'b1;
                    resp_ok_q    <= tbl_we_q;
                    resp_addr_q  <= tbl_we_q ? tbl_addr_q : '0;
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        resp_ok_q    <= 1'b0;
                        resp_addr_q  <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_ok    = resp_ok_q;
    assign resp_addr  = resp_addr_q;
    assign tbl_addr   = tbl_addr_q;
    assign tbl_we     = tbl_we_q;
    assign tbl_din    = tbl_din_q;

endmodule
`default_nettype wire

// File: tb/tb_g1_update_ctrl.sv
`default_nettype none
// tb_g1_update_ctrl : scoreboard bench for g1_update_ctrl driving a
// registered-read table model and a reference copy of the table contents.
module tb_g1_update_ctrl;

    localparam int TES = 154;
    localparam int EW  = 171;
    localparam int AW  = 11;

    typedef struct packed { logic ok; logic [AW-1:0] addr; logic [31:0] lat; } resp_t;
    typedef struct packed { logic [AW-1:0] addr; logic [EW-1:0] din; logic [31:0] lat; } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_op = 1'b0;
    logic [EW-1:0] req_entry = '0;
    logic          resp_ready = 1'b0;
    logic          req_ready;
    logic          resp_valid;
    logic          resp_ok;
    logic [AW-1:0] resp_addr;
    logic [AW-1:0] tbl_addr;
    logic          tbl_we;
    logic [EW-1:0] tbl_din;
    logic [EW-1:0] tbl_dout;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc = 0;
    bit resp_seen = 1'b0;

    resp_t exp_resp[$];
    resp_t obs_resp[$];
    wr_t   exp_wr[$];
    wr_t   obs_wr[$];

    logic [EW-1:0] mem     [0:TES];
    logic [EW-1:0] ref_mem [0:TES];

    always #5 clk = ~clk;

    g1_update_ctrl #(.TABLE_ENTRY_SIZE(TES), .ENTRY_W(EW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_entry(req_entry),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_ok(resp_ok), .resp_addr(resp_addr),
        .tbl_addr(tbl_addr), .tbl_we(tbl_we), .tbl_din(tbl_din), .tbl_dout(tbl_dout)
    );

    // Table model: single port, registered read.
    always @(posedge clk) begin
        if (tbl_we && (tbl_addr <= AW'(TES))) mem[tbl_addr] <= tbl_din;
        tbl_dout <= (tbl_addr <= AW'(TES)) ? mem[tbl_addr] : '1;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && req_valid && req_ready) acc_cyc <= cyc;
    end

    // Monitor: records writes and the first cycle of each response, with latency from accept.
    always @(negedge clk) begin
        if (rst_n && tbl_we) obs_wr.push_back(wr_t'({tbl_addr, tbl_din, 32'(cyc - acc_cyc)}));
        if (rst_n && resp_valid && !resp_seen)
            obs_resp.push_back(resp_t'({resp_ok, resp_addr, 32'(cyc - acc_cyc)}));
        resp_seen = rst_n && resp_valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [EW-1:0] mk(input logic [10:0] rid);
        return {$urandom(), $urandom(), $urandom(), $urandom(), 21'($urandom()), rid, 11'h3A5};
    endfunction

    function automatic int find_slot(input bit del, input logic [10:0] rid);
        for (int i = 0; i <= TES; i++) begin
            if (del ? (ref_mem[i][21:11] == rid) : (ref_mem[i][21:11] == 11'h7FF)) return i;
        end
        return -1;
    endfunction

    function automatic int tbl_diffs();
        int n = 0;
        for (int i = 0; i <= TES; i++) if (mem[i] !== ref_mem[i]) n++;
        return n;
    endfunction

    function automatic resp_t take_resp();
        if (obs_resp.size() == 0) return '1;
        return obs_resp.pop_front();
    endfunction

    function automatic wr_t take_wr();
        if (obs_wr.size() == 0) return '1;
        return obs_wr.pop_front();
    endfunction

    task automatic flush();
        exp_resp.delete(); obs_resp.delete(); exp_wr.delete(); obs_wr.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        flush();
    endtask

    task automatic fill_empty();
        for (int i = 0; i <= TES; i++) begin
            mem[i] <= '1;
            ref_mem[i] = '1;
        end
    endtask

    task automatic put(input int i, input logic [EW-1:0] v);
        mem[i] <= v;
        ref_mem[i] = v;
    endtask

    // Scoreboard producer: expected write and response for one request.
    task automatic expect_op(input bit del, input logic [EW-1:0] ent);
        int s;
        logic [EW-1:0] d;
        if (ent[21:11] == 11'h7FF) begin
            exp_resp.push_back(resp_t'({1'b0, 11'd0, 32'd1}));
            return;
        end
        s = find_slot(del, ent[21:11]);
        if (s < 0) begin
            exp_resp.push_back(resp_t'({1'b0, 11'd0, 32'(TES + 4)}));
        end else begin
            d = del ? '1 : {ent[EW-1:AW], AW'(s)};
            exp_wr.push_back(wr_t'({AW'(s), d, 32'(s + 3)}));
            exp_resp.push_back(resp_t'({1'b1, AW'(s), 32'(s + 4)}));
            ref_mem[s] = d;
        end
    endtask

    task automatic send_req(input bit del, input logic [EW-1:0] ent, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
        end
        if (ok) begin
            req_valid = 1'b1; req_op = del; req_entry = ent;
            @(posedge clk);
            #1 req_valid = 1'b0;
        end
    endtask

    task automatic wait_resp(output bit got);
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (resp_valid) got = 1'b1;
        end
    endtask

    task automatic ack_resp();
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic issue(input bit del, input logic [EW-1:0] ent);
        bit ok, got;
        expect_op(del, ent);
        send_req(del, ent, ok);
        if (ok) begin
            wait_resp(got);
            if (got) ack_resp();
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_chk++;
        if ({req_ready, resp_valid, resp_ok, resp_addr, tbl_we, tbl_addr} !== {1'b1, 1'b0, 1'b0, 11'd0, 1'b0, 11'd0}) begin
            n_fail++;
            $display("FAIL reset_ctrl got rdy=%b rv=%b ok=%b ra=%0d we=%b ta=%0d exp rdy=1 rest 0",
                     req_ready, resp_valid, resp_ok, resp_addr, tbl_we, tbl_addr);
        end
        n_chk++;
        if (tbl_din !== '0) begin
            n_fail++;
            $display("FAIL reset_din got=%h exp=0", tbl_din);
        end
    endtask

    task automatic test_insert_empty();
        resp_t xr, gr;
        wr_t   xw, gw;
        do_reset();
        fill_empty();
        issue(1'b0, mk(11'd5));
        n_chk++;
        if (obs_wr.size() != exp_wr.size()) begin
            n_fail++; $display("FAIL ins_empty_wrcount got=%0d exp=%0d", obs_wr.size(), exp_wr.size());
        end
        while (exp_wr.size() > 0) begin
            xw = exp_wr.pop_front(); gw = take_wr(); n_chk++;
            if (gw !== xw) begin
                n_fail++; $display("FAIL ins_empty_wr got a=%0d lat=%0d din=%h exp a=%0d lat=%0d din=%h", gw.addr, gw.lat, gw.din, xw.addr, xw.lat, xw.din);
            end
        end
        while (exp_resp.size() > 0) begin
            xr = exp_resp.pop_front(); gr = take_resp(); n_chk++;
            if (gr !== xr) begin
                n_fail++; $display("FAIL ins_empty_resp got ok=%b a=%0d lat=%0d exp ok=%b a=%0d lat=%0d", gr.ok, gr.addr, gr.lat, xr.ok, xr.addr, xr.lat);
            end
        end
        n_chk++;
        if (tbl_diffs() != 0) begin
            n_fail++; $display("FAIL ins_empty_table got diffs=%0d exp=0", tbl_diffs());
        end
    endtask

    task automatic test_insert_gap();
        resp_t xr, gr;
        wr_t   xw, gw;
        do_reset();
        fill_empty();
        for (int i = 0; i < 10; i++) put(i, mk(11'(100 + i)));
        issue(1'b0, mk(11'd6));
        n_chk++;
        if (obs_wr.size() != exp_wr.size()) begin
            n_fail++; $display("FAIL ins_gap_wrcount got=%0d exp=%0d", obs_wr.size(), exp_wr.size());
        end
        while (exp_wr.size() > 0) begin
            xw = exp_wr.pop_front(); gw = take_wr(); n_chk++;
            if (gw !== xw) begin
                n_fail++; $display("FAIL ins_gap_wr got a=%0d lat=%0d din=%h exp a=%0d lat=%0d din=%h", gw.addr, gw.lat, gw.din, xw.addr, xw.lat, xw.din);
            end
        end
        while (exp_resp.size() > 0) begin
            xr = exp_resp.pop_front(); gr = take_resp(); n_chk++;
            if (gr !== xr) begin
                n_fail++; $display("FAIL ins_gap_resp got ok=%b a=%0d lat=%0d exp ok=%b a=%0d lat=%0d", gr.ok, gr.addr, gr.lat, xr.ok, xr.addr, xr.lat);
            end
        end
        n_chk++;
        if (tbl_diffs() != 0) begin
            n_fail++; $display("FAIL ins_gap_table got diffs=%0d exp=0", tbl_diffs());
        end
    endtask

    task automatic test_table_full();
        resp_t xr, gr;
        do_reset();
        for (int i = 0; i <= TES; i++) put(i, mk(11'(i)));
        issue(1'b0, mk(11'd500));
        n_chk++;
        if (obs_wr.size() != 0) begin
            n_fail++; $display("FAIL full_nowrite got writes=%0d exp=0", obs_wr.size());
        end
        while (exp_resp.size() > 0) begin
            xr = exp_resp.pop_front(); gr = take_resp(); n_chk++;
            if (gr !== xr) begin
                n_fail++; $display("FAIL full_resp got ok=%b a=%0d lat=%0d exp ok=%b a=%0d lat=%0d", gr.ok, gr.addr, gr.lat, xr.ok, xr.addr, xr.lat);
            end
        end
        n_chk++;
        if (tbl_diffs() != 0) begin
            n_fail++; $display("FAIL full_table got diffs=%0d exp=0", tbl_diffs());
        end
    endtask

    task automatic test_delete();
        resp_t xr, gr;
        wr_t   xw, gw;
        do_reset();
        fill_empty();
        put(3, mk(11'd41));
        put(7, mk(11'd42));
        put(20, mk(11'd42));
        issue(1'b1, mk(11'd42));
        issue(1'b1, mk(11'd42));
        issue(1'b1, mk(11'd77));
        n_chk++;
        if (obs_wr.size() != exp_wr.size()) begin
            n_fail++; $display("FAIL del_wrcount got=%0d exp=%0d", obs_wr.size(), exp_wr.size());
        end
        while (exp_wr.size() > 0) begin
            xw = exp_wr.pop_front(); gw = take_wr(); n_chk++;
            if (gw !== xw) begin
                n_fail++; $display("FAIL del_wr got a=%0d lat=%0d din=%h exp a=%0d lat=%0d din=%h", gw.addr, gw.lat, gw.din, xw.addr, xw.lat, xw.din);
            end
        end
        while (exp_resp.size() > 0) begin
            xr = exp_resp.pop_front(); gr = take_resp(); n_chk++;
            if (gr !== xr) begin
                n_fail++; $display("FAIL del_resp got ok=%b a=%0d lat=%0d exp ok=%b a=%0d lat=%0d", gr.ok, gr.addr, gr.lat, xr.ok, xr.addr, xr.lat);
            end
        end
        n_chk++;
        if (tbl_diffs() != 0) begin
            n_fail++; $display("FAIL del_table got diffs=%0d exp=0", tbl_diffs());
        end
    endtask

    task automatic test_illegal_hold();
        resp_t xr, gr;
        logic [EW-1:0] ent;
        bit ok, got;
        do_reset();
        fill_empty();
        ent = mk(11'h7FF);
        expect_op(1'b1, ent);
        send_req(1'b1, ent, ok);
        wait_resp(got);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_chk++;
            if ({resp_valid, req_ready, resp_ok} !== 3'b100) begin
                n_fail++; $display("FAIL hold_%0d got rv=%b rdy=%b ok=%b exp rv=1 rdy=0 ok=0", i, resp_valid, req_ready, resp_ok);
            end
        end
        ack_resp();
        @(negedge clk);
        n_chk++;
        if ({req_ready, resp_valid} !== 2'b10) begin
            n_fail++; $display("FAIL hold_release got rdy=%b rv=%b exp rdy=1 rv=0", req_ready, resp_valid);
        end
        while (exp_resp.size() > 0) begin
            xr = exp_resp.pop_front(); gr = take_resp(); n_chk++;
            if (gr !== xr) begin
                n_fail++; $display("FAIL illegal_resp got ok=%b a=%0d lat=%0d exp ok=%b a=%0d lat=%0d", gr.ok, gr.addr, gr.lat, xr.ok, xr.addr, xr.lat);
            end
        end
        n_chk++;
        if (obs_wr.size() != 0) begin
            n_fail++; $display("FAIL illegal_nowrite got writes=%0d exp=0", obs_wr.size());
        end
    endtask

    task automatic test_reset_mid();
        resp_t xr, gr;
        wr_t   xw, gw;
        bit ok, saw;
        do_reset();
        fill_empty();
        for (int i = 0; i < 50; i++) put(i, mk(11'(200 + i)));
        send_req(1'b0, mk(11'd9), ok);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({tbl_we, req_ready, tbl_addr} !== {1'b0, 1'b1, 11'd0}) begin
            n_fail++; $display("FAIL rst_scan got we=%b rdy=%b ta=%0d exp we=0 rdy=1 ta=0", tbl_we, req_ready, tbl_addr);
        end
        @(negedge clk) rst_n = 1'b1;
        send_req(1'b0, mk(11'd9), ok);
        saw = 1'b0;
        for (int i = 0; i < 100 && !saw; i++) begin
            @(negedge clk);
            if (tbl_we) saw = 1'b1;
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({saw, tbl_we, req_ready} !== 3'b101) begin
            n_fail++; $display("FAIL rst_write got saw_we=%b we=%b rdy=%b exp saw_we=1 we=0 rdy=1", saw, tbl_we, req_ready);
        end
        @(negedge clk) rst_n = 1'b1;
        n_chk++;
        if (tbl_diffs() != 0) begin
            n_fail++; $display("FAIL rst_table got diffs=%0d exp=0", tbl_diffs());
        end
        flush();
        issue(1'b0, mk(11'd9));
        while (exp_wr.size() > 0) begin
            xw = exp_wr.pop_front(); gw = take_wr(); n_chk++;
            if (gw !== xw) begin
                n_fail++; $display("FAIL rst_after_wr got a=%0d lat=%0d din=%h exp a=%0d lat=%0d din=%h", gw.addr, gw.lat, gw.din, xw.addr, xw.lat, xw.din);
            end
        end
        while (exp_resp.size() > 0) begin
            xr = exp_resp.pop_front(); gr = take_resp(); n_chk++;
            if (gr !== xr) begin
                n_fail++; $display("FAIL rst_after_resp got ok=%b a=%0d lat=%0d exp ok=%b a=%0d lat=%0d", gr.ok, gr.addr, gr.lat, xr.ok, xr.addr, xr.lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        resp_t xr, gr;
        do_reset();
        fill_empty();
        put(0, mk(11'd300));
        issue(1'b0, mk(11'd301));
        issue(1'b0, mk(11'd302));
        issue(1'b1, mk(11'd300));
        n_chk++;
        if (obs_wr.size() != 3) begin
            n_fail++; $display("FAIL b2b_wrcount got=%0d exp=3", obs_wr.size());
        end
        while (exp_resp.size() > 0) begin
            xr = exp_resp.pop_front(); gr = take_resp(); n_chk++;
            if (gr !== xr) begin
                n_fail++; $display("FAIL b2b_resp got ok=%b a=%0d lat=%0d exp ok=%b a=%0d lat=%0d", gr.ok, gr.addr, gr.lat, xr.ok, xr.addr, xr.lat);
            end
        end
        n_chk++;
        if (tbl_diffs() != 0) begin
            n_fail++; $display("FAIL b2b_table got diffs=%0d exp=0", tbl_diffs());
        end
    endtask

    initial begin
        test_reset();
        test_insert_empty();
        test_insert_gap();
        test_table_full();
        test_delete();
        test_illegal_hold();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
